// File: rtl/bin_morph_pkg.sv
// bin_morph_pkg: shared constants and helpers for the binary morphology stage.
//   MODE_ERODE / MODE_DILATE : values of the per-frame mode input
//   FG_COLOR_DEF / BG_COLOR_DEF : default RGB565 output words
//   morph_radius()           : window radius R = (WIN-1)/2
package bin_morph_pkg;

  localparam logic MODE_ERODE  = 1'b0;
  localparam logic MODE_DILATE = 1'b1;

  localparam logic [15:0] FG_COLOR_DEF = 16'h0000;
  localparam logic [15:0] BG_COLOR_DEF = 16'hFFFF;

  // Window radius; WIN is expected to be 3 or 5.
  function automatic int unsigned morph_radius(input int unsigned win);
    return (win - 1) / 2;
  endfunction

endpackage

// File: rtl/bin_morph_if.sv
// bin_morph_if: pixel-in / SDRAM-word-out bundle of the morphology stage.
//   frame_start, mode, data_en, pix : pixel stream from the threshold stage
//   sdram_wr_en, sdram_wr_data      : result stream toward the SDRAM write port
//   fg_count                        : last-frame foreground count (MORPH_FG_COUNT_EN only)
// Modports: slave = morphology block, master = stream source / sink side.
interface bin_morph_if
`ifdef MORPH_FG_COUNT_EN
  #(parameter int unsigned CNT_W = 19)
`endif
  ;

  logic        frame_start;
  logic        mode;
  logic        data_en;
  logic        pix;
  logic        sdram_wr_en;
  logic [15:0] sdram_wr_data;
`ifdef MORPH_FG_COUNT_EN
  logic [CNT_W-1:0] fg_count;
`endif

  modport slave (
    input  frame_start, mode, data_en, pix,
`ifdef MORPH_FG_COUNT_EN
    output fg_count,
`endif
    output sdram_wr_en, sdram_wr_data
  );

  modport master (
    output frame_start, mode, data_en, pix,
`ifdef MORPH_FG_COUNT_EN
    input  fg_count,
`endif
    input  sdram_wr_en, sdram_wr_data
  );

endinterface

// File: rtl/bin_morph_line_buf.sv
// bin_morph_line_buf: LINES cascaded 1-bit line delays of IMG_W pixels each.
//   clk    : pixel clock
//   en_i   : shift enable (one pixel per enabled cycle)
//   col_i  : current column, used as the RAM address
//   din_i  : new pixel entering line 0
//   taps_o : taps_o[l] = pixel from l+1 lines ago at column col_i
// Each line is a RAM read before write at the same address, so the tap
// shows the previous line's pixel while the new one is stored. No reset:
// stale contents are hidden by the border mask downstream.
module bin_morph_line_buf #(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned LINES = 2,
  localparam int unsigned CW   = $clog2(IMG_W)
) (
  input  logic             clk,
  input  logic             en_i,
  input  logic [CW-1:0]    col_i,
  input  logic             din_i,
  output logic [LINES-1:0] taps_o
);

  for (genvar l = 0; l < LINES; l++) begin : g_line
    logic mem_q [IMG_W];
    logic din;

    if (l == 0) begin : g_first
      assign din = din_i;
    end else begin : g_chain
      assign din = taps_o[l-1];
    end

    // Asynchronous read of the old word, write of the new one on enable.
    assign taps_o[l] = mem_q[col_i];

    always_ff @(posedge clk) begin
      if (en_i) begin
        mem_q[col_i] <= din;
      end
    end
  end

endmodule

// File: rtl/bin_morph.sv
// bin_morph: WIN x WIN binary erosion/dilation over a raster 1-bit stream,
// producing one RGB565 black/white word per input pixel, 3 cycles after
// the window update.
//   clk, rst : pixel clock, asynchronous active-high reset
//   bus      : bin_morph_if.slave (frame_start, mode, data_en, pix in;
//              sdram_wr_en, sdram_wr_data, optional fg_count out)
// Optional feature: define MORPH_FG_COUNT_EN to add the per-frame
// foreground counter and the fg_count output.
module bin_morph
  import bin_morph_pkg::*;
#(
  parameter int unsigned IMG_W    = 640,
  parameter int unsigned IMG_H    = 480,
  parameter int unsigned WIN      = 3,
  parameter logic [15:0] FG_COLOR = FG_COLOR_DEF,
  parameter logic [15:0] BG_COLOR = BG_COLOR_DEF
) (
  input logic        clk,
  input logic        rst,
  bin_morph_if.slave bus
);

  localparam int unsigned R     = morph_radius(WIN);
  localparam int unsigned LINES = 2 * R;
  localparam int unsigned CW    = $clog2(IMG_W);
  localparam int unsigned RW    = $clog2(IMG_H);

  logic [CW-1:0] col_q, col_d, col_cur;
  logic [RW-1:0] row_q, row_d, row_cur;
  logic          mode_q, mode_d, mode_cur;

  logic [LINES-1:0]           taps;
  logic [WIN-1:0]             new_col;
  logic [WIN-1:0][WIN-1:0]    win_q, win_d;
  logic [WIN-1:0]             row_red;

  logic           s0_vld_q, s0_vld_d, s0_border_q, s0_border_d, s0_mode_q, s0_mode_d;
  logic [WIN-1:0] s1_red_q, s1_red_d;
  logic           s1_vld_q, s1_vld_d, s1_border_q, s1_border_d, s1_mode_q, s1_mode_d;
  logic           s2_vld_q, s2_vld_d, s2_fg_q, s2_fg_d;
  logic           wr_en_q, wr_en_d;
  logic [15:0]    wr_data_q, wr_data_d;

  bin_morph_line_buf #(
    .IMG_W (IMG_W),
    .LINES (LINES)
  ) u_line_buf (
    .clk    (clk),
    .en_i   (bus.data_en),
    .col_i  (col_cur),
    .din_i  (bus.pix),
    .taps_o (taps)
  );

  // Window rows: row WIN-1 is the live pixel, row 0 the oldest line.
  for (genvar r = 0; r < WIN; r++) begin : g_win
    if (r == WIN - 1) begin : g_pix
      assign new_col[r] = bus.pix;
    end else begin : g_tap
      assign new_col[r] = taps[LINES-1-r];
    end
    assign win_d[r] = bus.data_en ? {new_col[r], win_q[r][WIN-1:1]} : win_q[r];
    // Per-row fg test on pixel polarity (fg = 0): any-fg for dilation, all-fg for erosion.
    assign row_red[r] = (s0_mode_q == MODE_DILATE) ? ~&win_q[r] : ~|win_q[r];
  end

  // Counters, mode latch and the reduction pipeline.
  always_comb begin
    col_cur  = bus.frame_start ? '0 : col_q;
    row_cur  = bus.frame_start ? '0 : row_q;
    mode_cur = bus.frame_start ? bus.mode : mode_q;

    col_d       = col_cur;
    row_d       = row_cur;
    mode_d      = mode_cur;
    s0_vld_d    = bus.data_en;
    s0_border_d = s0_border_q;
    s0_mode_d   = s0_mode_q;

    if (bus.data_en) begin
      if (col_cur == CW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (row_cur == RW'(IMG_H - 1)) ? '0 : row_cur + 1'b1;
      end else begin
        col_d = col_cur + 1'b1;
      end
      s0_border_d = (row_cur < RW'(LINES)) || (col_cur < CW'(LINES));
      s0_mode_d   = mode_cur;
    end

    s1_vld_d    = s0_vld_q;
    s1_border_d = s0_border_q;
    s1_mode_d   = s0_mode_q;
    s1_red_d    = row_red;

    s2_vld_d = s1_vld_q;
    s2_fg_d  = ~s1_border_q & ((s1_mode_q == MODE_DILATE) ? |s1_red_q : &s1_red_q);

    wr_en_d   = s2_vld_q;
    wr_data_d = wr_data_q;
    if (s2_vld_q) begin
      wr_data_d = s2_fg_q ? FG_COLOR : BG_COLOR;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      mode_q      <= MODE_ERODE;
      win_q       <= '1;
      s0_vld_q    <= 1'b0;
      s0_border_q <= 1'b1;
      s0_mode_q   <= MODE_ERODE;
      s1_red_q    <= '0;
      s1_vld_q    <= 1'b0;
      s1_border_q <= 1'b1;
      s1_mode_q   <= MODE_ERODE;
      s2_vld_q    <= 1'b0;
      s2_fg_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= 16'h0000;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      mode_q      <= mode_d;
      win_q       <= win_d;
      s0_vld_q    <= s0_vld_d;
      s0_border_q <= s0_border_d;
      s0_mode_q   <= s0_mode_d;
      s1_red_q    <= s1_red_d;
      s1_vld_q    <= s1_vld_d;
      s1_border_q <= s1_border_d;
      s1_mode_q   <= s1_mode_d;
      s2_vld_q    <= s2_vld_d;
      s2_fg_q     <= s2_fg_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign bus.sdram_wr_en   = wr_en_q;
  assign bus.sdram_wr_data = wr_data_q;

`ifdef MORPH_FG_COUNT_EN
  localparam int unsigned CNT_W = $clog2(IMG_W * IMG_H + 1);

  logic             s0_last_q, s0_last_d, s1_last_q, s1_last_d, s2_last_q, s2_last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc, fg_count_q, fg_count_d;

  // Last-pixel marker rides the pipeline; its output beat publishes the total.
  always_comb begin
    s0_last_d = s0_last_q;
    if (bus.data_en) begin
      s0_last_d = (row_cur == RW'(IMG_H - 1)) && (col_cur == CW'(IMG_W - 1));
    end
    s1_last_d = s0_last_q;
    s2_last_d = s1_last_q;

    cnt_inc    = cnt_q + CNT_W'(s2_vld_q & s2_fg_q);
    cnt_d      = cnt_inc;
    fg_count_d = fg_count_q;
    if (s2_vld_q && s2_last_q) begin
      fg_count_d = cnt_inc;
      cnt_d      = '0;
    end
    if (bus.frame_start) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_last_q  <= 1'b0;
      s1_last_q  <= 1'b0;
      s2_last_q  <= 1'b0;
      cnt_q      <= '0;
      fg_count_q <= '0;
    end else begin
      s0_last_q  <= s0_last_d;
      s1_last_q  <= s1_last_d;
      s2_last_q  <= s2_last_d;
      cnt_q      <= cnt_d;
      fg_count_q <= fg_count_d;
    end
  end

  assign bus.fg_count = fg_count_q;
`endif

endmodule
